// File: rtl/dmem_bytelane.sv
// rtl/dmem_bytelane.sv - RV32 byte-lane data memory with valid/ready request and pulsed response
// Optional fault detection: define DMEM_FAULT_EN.
module dmem_bytelane #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LDFMT, RESP} state_t;

  state_t      state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [31:0] raw;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [1:0]  off_q;
  logic        byte_q, half_q, uns_q;

  logic             accept;
  logic             illegal, is_byte, is_half, fault;
  logic [1:0]       off;
  logic [3:0]       lanes;
  logic [31:0]      wdata_al;
  logic [IDX_W-1:0] idx;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      fmt;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_fault = (state == RESP) && fault_q;
  assign rsp_rdata = rdata_q;
  assign idx       = req_addr[IDX_W+1:2];

  // Decode width, effective lane offset, lane enables and lane-replicated store data
  always_comb begin
    illegal  = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11) ||
               (req_we && req_funct3[2]);
    // Illegal codes fall back to a word access when faults are not reported
    is_byte  = !illegal && (req_funct3[1:0] == 2'b00);
    is_half  = !illegal && (req_funct3[1:0] == 2'b01);
    off      = is_byte ? req_addr[1:0] : (is_half ? {req_addr[1], 1'b0} : 2'b00);
    lanes    = is_byte ? (4'b0001 << off) : (is_half ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    wdata_al = is_byte ? {4{req_wdata[7:0]}} : (is_half ? {2{req_wdata[15:0]}} : req_wdata);
  end

`ifdef DMEM_FAULT_EN
  // Misaligned, out-of-range and illegal requests are rejected without side effects
  always_comb begin
    fault = illegal ||
            (is_half && req_addr[0]) ||
            (!is_byte && !is_half && (req_addr[1:0] != 2'b00)) ||
            ((req_addr >> (IDX_W + 2)) != '0);
  end
`else
  // Upper address bits are ignored: accesses wrap modulo the memory size
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  assign fault = 1'b0;
`endif

  // Select the addressed byte/half from the raw word and extend it
  always_comb begin
    byte_v = raw[{off_q, 3'b000} +: 8];
    half_v = raw[{off_q[1], 4'b0000} +: 16];
    if (byte_q)
      fmt = {{24{!uns_q && byte_v[7]}}, byte_v};
    else if (half_q)
      fmt = {{16{!uns_q && half_v[15]}}, half_v};
    else
      fmt = raw;
  end

  // Next-state logic: store/fault responds next cycle, load formats first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (fault || req_we) ? RESP : LDFMT;
      LDFMT:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control state and latched request attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      fault_q <= 1'b0;
      off_q   <= 2'b00;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rdata_q <= '0;
        fault_q <= fault;
        off_q   <= off;
        byte_q  <= is_byte;
        half_q  <= is_half;
        uns_q   <= req_funct3[2];
      end else if (state == LDFMT) begin
        rdata_q <= fmt;
      end
    end
  end

  // Storage array: lane writes and raw word read at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && !fault) begin
      if (req_we) begin
        for (int i = 0; i < 4; i++)
          if (lanes[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end else begin
        raw <= mem[idx];
      end
    end
  end

endmodule
